hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 50 +++++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard controller.
//   Pipeline status (master -> slave):
//     d_src1, d_src2 : decode-stage source register indices
//     d_jump         : decode resolves a taken branch/jump this cycle
//     e_icode        : execute-stage opcode
//     e_dst          : execute-stage destination register
//     i_busy         : instruction fetch outstanding (fetch data not valid)
//     d_busy         : data-memory access outstanding in the memory stage
//   Pipeline controls (slave -> master):
//     f_stall, d_stall, m_stall    : hold F, D, M pipeline registers
//     d_bubble, e_bubble, w_bubble : load a NOP into D, E, W
//     f_flush                      : discard the in-flight fetch result
//     hz_state                     : controller state (RUN/IWAIT/DWAIT/FLUSH)
//     stall_cnt                    : saturating count of f_stall cycles
//   The master modport is the datapath side; the slave modport is the
//   hazard controller.
// ----------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [4:0]  d_src1;
  logic [4:0]  d_src2;
  logic        d_jump;
  logic [5:0]  e_icode;
  logic [4:0]  e_dst;
  logic        i_busy;
  logic        d_busy;

  logic        f_stall;
  logic        d_stall;
  logic        m_stall;
  logic        d_bubble;
  logic        e_bubble;
  logic        w_bubble;
  logic        f_flush;
  logic [1:0]  hz_state;
  logic [15:0] stall_cnt;

  modport master (
    output d_src1, d_src2, d_jump, e_icode, e_dst, i_busy, d_busy,
    input  f_stall, d_stall, m_stall, d_bubble, e_bubble, w_bubble,
           f_flush, hz_state, stall_cnt
  );

  modport slave (
    input  d_src1, d_src2, d_jump, e_icode, e_dst, i_busy, d_busy,
    output f_stall, d_stall, m_stall, d_bubble, e_bubble, w_bubble,
           f_flush, hz_state, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller: detects load-use hazards, waits out slow
//   instruction fetches and data-memory accesses, and flushes a stale fetch
//   when a redirect was resolved while the fetch was still outstanding.
//
//   Ports:
//     clk   : sole clock, all state updates on its rising edge
//     reset : asynchronous active-high reset
//     hz    : hazard_ctrl_if.slave (pipeline status in, stall/bubble/flush
//             controls, state and stall counter out)
//
//   Parameter:
//     LW_OP : opcode that marks a load in the execute stage
//
//   All control outputs are combinational from the current state and the
//   pipeline status; priority is d_busy > load-use > i_busy. While reset is
//   asserted every control output is forced low.
// ----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter logic [5:0] LW_OP = 6'b100011
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        pend_reg, pend_next;
  logic [15:0] cnt_reg;

  logic luse;
  logic f_stall_c, d_stall_c, m_stall_c;
  logic d_bubble_c, e_bubble_c, w_bubble_c, f_flush_c;

  // Load in E whose destination feeds D; r0 is never a real dependency.
  assign luse = (hz.e_icode == LW_OP) && (hz.e_dst != 5'd0) &&
                ((hz.d_src1 == hz.e_dst) || (hz.d_src2 == hz.e_dst));

  // State, pending-redirect flag and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      pend_reg  <= 1'b0;
      cnt_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      if (f_stall_c && (cnt_reg != 16'hFFFF))
        cnt_reg <= cnt_reg + 16'd1;
    end
  end

  // Next-state and raw control outputs.
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    f_stall_c  = 1'b0;
    d_stall_c  = 1'b0;
    m_stall_c  = 1'b0;
    d_bubble_c = 1'b0;
    e_bubble_c = 1'b0;
    w_bubble_c = 1'b0;
    f_flush_c  = 1'b0;

    if (hz.d_busy) begin
      // Memory stall freezes everything up to M; the pending redirect
      // survives so the wait we interrupted can be resumed afterwards.
      f_stall_c  = 1'b1;
      d_stall_c  = 1'b1;
      m_stall_c  = 1'b1;
      w_bubble_c = 1'b1;
      state_next = DWAIT;
      if ((state_reg == IWAIT) && hz.d_jump)
        pend_next = 1'b1;
    end else begin
      unique case (state_reg)
        RUN, DWAIT: begin
          if (luse) begin
            f_stall_c  = 1'b1;
            d_stall_c  = 1'b1;
            e_bubble_c = 1'b1;
          end else if (hz.i_busy) begin
            f_stall_c  = 1'b1;
            d_bubble_c = 1'b1;
          end

          if (state_reg == RUN) begin
            if (!luse && hz.i_busy) begin
              state_next = IWAIT;
              if (hz.d_jump)
                pend_next = 1'b1;
            end
          end else begin
            // Leaving a memory wait: resume the fetch wait if one was
            // interrupted (redirect pending) or the fetch is still busy.
            state_next = (pend_reg || hz.i_busy) ? IWAIT : RUN;
          end
        end

        IWAIT: begin
          // D already holds a bubble here, so load-use needs no action.
          if (hz.d_jump)
            pend_next = 1'b1;
          if (hz.i_busy) begin
            f_stall_c  = 1'b1;
            d_bubble_c = 1'b1;
          end else begin
            state_next = pend_reg ? FLUSH : RUN;
          end
        end

        FLUSH: begin
          // The fetch that just landed came from the wrong path.
          f_flush_c  = 1'b1;
          d_bubble_c = 1'b1;
          state_next = RUN;
          pend_next  = 1'b0;
        end

        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign hz.f_stall   = f_stall_c  & ~reset;
  assign hz.d_stall   = d_stall_c  & ~reset;
  assign hz.m_stall   = m_stall_c  & ~reset;
  assign hz.d_bubble  = d_bubble_c & ~reset;
  assign hz.e_bubble  = e_bubble_c & ~reset;
  assign hz.w_bubble  = w_bubble_c & ~reset;
  assign hz.f_flush   = f_flush_c  & ~reset;
  assign hz.hz_state  = state_reg;
  assign hz.stall_cnt = cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [5:0] LW = 6'b100011;

  // Reference model modes (named by meaning, not by RTL encoding use).
  localparam int M_RUN   = 0;
  localparam int M_IWAIT = 1;
  localparam int M_DWAIT = 2;
  localparam int M_FLUSH = 3;

  typedef struct packed {
    logic        f_stall;
    logic        d_stall;
    logic        m_stall;
    logic        d_bubble;
    logic        e_bubble;
    logic        w_bubble;
    logic        f_flush;
    logic [1:0]  st;
    logic [15:0] cnt;
  } obs_t;

  logic clk;
  logic reset;
  hazard_ctrl_if bus ();

  hazard_ctrl #(.LW_OP(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  // Model state
  int mdl_mode = M_RUN;
  bit mdl_pend = 1'b0;
  int mdl_cnt  = 0;

  // Evaluate one cycle of the rules and advance the model past the edge.
  task automatic model_cycle(input logic r, input logic [4:0] s1, s2,
                             input logic j, input logic [5:0] ic,
                             input logic [4:0] dst, input logic ib, db,
                             output obs_t e);
    bit ld_use;
    int nmode;
    bit npend;
    e = '0;
    e.st  = 2'(mdl_mode);
    e.cnt = 16'(mdl_cnt);
    if (r) begin
      e = '0;
      mdl_mode = M_RUN;
      mdl_pend = 1'b0;
      mdl_cnt  = 0;
      return;
    end
    ld_use = (ic == LW) && (dst != 0) && (s1 == dst || s2 == dst);
    nmode  = mdl_mode;
    npend  = mdl_pend;
    if (db) begin
      e.f_stall = 1; e.d_stall = 1; e.m_stall = 1; e.w_bubble = 1;
      nmode = M_DWAIT;
      if (mdl_mode == M_IWAIT && j) npend = 1;
    end else if (mdl_mode == M_FLUSH) begin
      e.f_flush = 1; e.d_bubble = 1;
      nmode = M_RUN;
      npend = 0;
    end else if (mdl_mode == M_IWAIT) begin
      if (j) npend = 1;
      if (ib) begin
        e.f_stall = 1; e.d_bubble = 1;
      end else begin
        nmode = mdl_pend ? M_FLUSH : M_RUN;
      end
    end else begin
      // RUN, or DWAIT with memory done: run rules for outputs
      if (ld_use) begin
        e.f_stall = 1; e.d_stall = 1; e.e_bubble = 1;
      end else if (ib) begin
        e.f_stall = 1; e.d_bubble = 1;
      end
      if (mdl_mode == M_DWAIT) begin
        nmode = (mdl_pend || ib) ? M_IWAIT : M_RUN;
      end else if (!ld_use && ib) begin
        nmode = M_IWAIT;
        if (j) npend = 1;
      end
    end
    if (e.f_stall && mdl_cnt < 65535) mdl_cnt = mdl_cnt + 1;
    mdl_mode = nmode;
    mdl_pend = npend;
  endtask

  task automatic drive(input logic r, input logic [4:0] s1, s2,
                       input logic j, input logic [5:0] ic,
                       input logic [4:0] dst, input logic ib, db,
                       input string tag);
    obs_t e;
    @(posedge clk);
    #1;
    reset       = r;
    bus.d_src1  = s1;
    bus.d_src2  = s2;
    bus.d_jump  = j;
    bus.e_icode = ic;
    bus.e_dst   = dst;
    bus.i_busy  = ib;
    bus.d_busy  = db;
    model_cycle(r, s1, s2, j, ic, dst, ib, db, e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic quiet(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // Monitor: compares the DUT's outputs each cycle against the scoreboard.
  initial begin
    obs_t  e;
    obs_t  a;
    string t;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {bus.f_stall, bus.d_stall, bus.m_stall, bus.d_bubble,
             bus.e_bubble, bus.w_bubble, bus.f_flush, bus.hz_state,
             bus.stall_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s cyc=%0d got fs/ds/ms/db/eb/wb/ff=%b%b%b%b%b%b%b st=%0d cnt=%0d expected %b%b%b%b%b%b%b st=%0d cnt=%0d",
                   t, cyc, a.f_stall, a.d_stall, a.m_stall, a.d_bubble,
                   a.e_bubble, a.w_bubble, a.f_flush, a.st, a.cnt,
                   e.f_stall, e.d_stall, e.m_stall, e.d_bubble,
                   e.e_bubble, e.w_bubble, e.f_flush, e.st, e.cnt);
        end else begin
          $display("ok %s cyc=%0d st=%0d cnt=%0d", t, cyc, a.st, a.cnt);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    reset       = 1'b1;
    bus.d_src1  = '0;
    bus.d_src2  = '0;
    bus.d_jump  = 1'b0;
    bus.e_icode = '0;
    bus.e_dst   = '0;
    bus.i_busy  = 1'b0;
    bus.d_busy  = 1'b0;

    // Reset state, including with noisy inputs held during reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    drive(1, 5, 5, 1, LW, 5, 1, 1, "reset_noisy");
    quiet("idle");

    // Load-use on src2
    drive(0, 0, 5, 0, LW, 5, 0, 0, "luse");
    quiet("luse_after");
    // Same, but destination r0
    drive(0, 0, 5, 0, LW, 0, 0, 0, "luse_r0");
    // Not a load
    drive(0, 5, 5, 0, 6'b000000, 5, 0, 0, "luse_notld");
    // Jump with no pending fetch
    drive(0, 0, 0, 1, 0, 0, 0, 0, "jump_idle");

    // Fetch wait, no jump
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0, "iwait");
    quiet("iwait_done");
    quiet("iwait_run");

    // Fetch wait with redirect in 2nd cycle
    drive(0, 0, 0, 0, 0, 0, 1, 0, "redir_1");
    drive(0, 0, 0, 1, 0, 0, 1, 0, "redir_2");
    drive(0, 0, 0, 0, 0, 0, 1, 0, "redir_3");
    quiet("redir_drop");
    quiet("redir_flush");
    quiet("redir_run");

    // Memory stall inside fetch wait with pending redirect
    drive(0, 0, 0, 0, 0, 0, 1, 0, "dw_1");
    drive(0, 0, 0, 1, 0, 0, 1, 0, "dw_jump");
    drive(0, 0, 0, 0, 0, 0, 1, 1, "dw_busy1");
    drive(0, 0, 0, 0, 0, 0, 1, 1, "dw_busy2");
    drive(0, 0, 0, 0, 0, 0, 1, 0, "dw_exit");
    drive(0, 0, 0, 0, 0, 0, 1, 0, "dw_iwait");
    quiet("dw_drop");
    quiet("dw_flush");
    quiet("dw_run");

    // Reset in the middle of a memory wait
    drive(0, 0, 0, 0, 0, 0, 0, 1, "rst_dw_1");
    drive(0, 0, 0, 0, 0, 0, 0, 1, "rst_dw_2");
    drive(1, 0, 0, 0, 0, 0, 0, 1, "rst_dw_reset");
    quiet("rst_dw_after");
    // Reset in the middle of a fetch wait
    drive(0, 0, 0, 1, 0, 0, 1, 0, "rst_iw_1");
    drive(1, 0, 0, 0, 0, 0, 1, 0, "rst_iw_reset");
    quiet("rst_iw_after");

    // Randomized traffic
    begin
      logic ib;
      ib = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        logic       r, j, db;
        logic [4:0] s1, s2, dst;
        logic [5:0] ic;
        if ($urandom_range(0, 99) < 20) ib = ~ib;
        r   = ($urandom_range(0, 199) == 0);
        j   = ($urandom_range(0, 99) < 20);
        db  = ($urandom_range(0, 99) < 10);
        s1  = 5'($urandom_range(0, 7));
        s2  = 5'($urandom_range(0, 7));
        dst = 5'($urandom_range(0, 7));
        ic  = ($urandom_range(0, 1) == 1) ? LW : 6'($urandom_range(0, 63));
        drive(r, s1, s2, j, ic, dst, ib, db, "rand");
      end
    end
    quiet("tail");

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 100) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
